// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deserialises 11-bit frames,
// folds E0/F0 prefixes into key-event flags and buffers events in a small FIFO.
module ps2_key_receiver #(
    parameter int unsigned FIFO_AW        = 3,
    parameter int unsigned SYNC_STAGES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 25000,
    parameter int unsigned DECODE_EN      = 1
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    input  logic               rdn,
    output logic [7:0]         data,
    output logic               is_ext,
    output logic               is_break,
    output logic               ready,
    output logic [FIFO_AW:0]   level,
    output logic               overflow,
    output logic               parity_err,
    output logic               frame_err
);

    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        DEC_IDLE,
        DEC_EXT,
        DEC_BRK,
        DEC_EXT_BRK
    } dec_state_t;

    // ------------------------------------------------------------------
    // Line synchronisers (reset to the idle-high bus level)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_last;
    logic                   sample;
    logic                   bit_in;

    // NOTE: every clocked process uses non-blocking assignments so that all
    // registers update together at the edge, independent of statement order.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_last  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_last  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign sample = clk_last & ~clk_sync[SYNC_STAGES-1];
    assign bit_in = data_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Frame deserialiser with watchdog
    // ------------------------------------------------------------------
    logic [3:0]      bit_cnt;
    logic [9:0]      shreg;
    logic [WD_W-1:0] wd_cnt;
    logic            rx_valid;
    logic [7:0]      rx_byte;

    // shreg collects bits 0..9; after ten shifts bit 0 (start) sits in shreg[0]
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            wd_cnt     <= '0;
            rx_valid   <= 1'b0;
            rx_byte    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (sample) begin
                wd_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (shreg[0] || !bit_in) begin
                        frame_err <= 1'b1;
                    end else if (!(^shreg[9:1])) begin
                        parity_err <= 1'b1;
                    end else begin
                        rx_valid <= 1'b1;
                        rx_byte  <= shreg[8:1];
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shreg   <= {bit_in, shreg[9:1]};
                end
            end else if (bit_cnt != 4'd0) begin
                if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    bit_cnt   <= '0;
                    wd_cnt    <= '0;
                    frame_err <= 1'b1;
                end else begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefix decoder
    // ------------------------------------------------------------------
    dec_state_t dec_state_q;
    dec_state_t dec_state_d;
    logic       push;
    logic [9:0] push_entry;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            dec_state_q <= DEC_IDLE;
        end else begin
            dec_state_q <= dec_state_d;
        end
    end

    // NOTE: defaults first so no path through this block leaves a signal
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        dec_state_d = dec_state_q;
        push        = 1'b0;
        push_entry  = {2'b00, rx_byte};
        if (rx_valid) begin
            if (DECODE_EN == 0) begin
                push = 1'b1;
            end else if (rx_byte == 8'hE0) begin
                case (dec_state_q)
                    DEC_IDLE: dec_state_d = DEC_EXT;
                    DEC_BRK:  dec_state_d = DEC_EXT_BRK;
                    default:  dec_state_d = dec_state_q;
                endcase
            end else if (rx_byte == 8'hF0) begin
                case (dec_state_q)
                    DEC_IDLE: dec_state_d = DEC_BRK;
                    DEC_EXT:  dec_state_d = DEC_EXT_BRK;
                    default:  dec_state_d = dec_state_q;
                endcase
            end else begin
                push        = 1'b1;
                push_entry  = {(dec_state_q == DEC_EXT) || (dec_state_q == DEC_EXT_BRK),
                               (dec_state_q == DEC_BRK) || (dec_state_q == DEC_EXT_BRK),
                               rx_byte};
                dec_state_d = DEC_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO: {ext, brk, byte}; extra pointer bit separates full/empty
    // ------------------------------------------------------------------
    logic [9:0]       mem [DEPTH];
    logic [FIFO_AW:0] w_ptr;
    logic [FIFO_AW:0] r_ptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             wr_en;
    logic             drop;

    assign empty = (w_ptr == r_ptr);
    assign full  = (w_ptr[FIFO_AW] != r_ptr[FIFO_AW]) &&
                   (w_ptr[FIFO_AW-1:0] == r_ptr[FIFO_AW-1:0]);
    assign pop   = ~rdn & ~empty;
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    // NOTE: the storage array has no reset; only the pointers define which
    // entries are valid, so clearing the contents would buy nothing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[w_ptr[FIFO_AW-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) w_ptr <= w_ptr + 1'b1;
            if (pop)   r_ptr <= r_ptr + 1'b1;
            // a drop and a pop cannot coincide, but set still takes priority
            if (drop) begin
                overflow <= 1'b1;
            end else if (pop) begin
                overflow <= 1'b0;
            end
        end
    end

    assign {is_ext, is_break, data} = mem[r_ptr[FIFO_AW-1:0]];
    assign ready = ~empty;
    assign level = w_ptr - r_ptr;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Randomised bench for ps2_key_receiver: a decoding and a raw instance share the
// PS/2 lines and are compared against a queue-based event model.
module tb_ps2_key_receiver;

    localparam int FIFO_AW = 3;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int TMO     = 300;
    localparam int HALF    = 20;

    logic clk = 1'b0;
    logic clrn = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic rdn = 1'b1;

    logic [7:0]       d_data, r_data;
    logic             d_ext, r_ext, d_brk, r_brk;
    logic             d_ready, r_ready, d_ovf, r_ovf;
    logic [FIFO_AW:0] d_level, r_level;
    logic             d_perr, r_perr, d_ferr, r_ferr;

    always #5 clk = ~clk;

    ps2_key_receiver #(.FIFO_AW(FIFO_AW), .SYNC_STAGES(3), .TIMEOUT_CYCLES(TMO), .DECODE_EN(1)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rdn(rdn),
        .data(d_data), .is_ext(d_ext), .is_break(d_brk), .ready(d_ready), .level(d_level),
        .overflow(d_ovf), .parity_err(d_perr), .frame_err(d_ferr));

    ps2_key_receiver #(.FIFO_AW(FIFO_AW), .SYNC_STAGES(3), .TIMEOUT_CYCLES(TMO), .DECODE_EN(0)) dut_raw (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rdn(rdn),
        .data(r_data), .is_ext(r_ext), .is_break(r_brk), .ready(r_ready), .level(r_level),
        .overflow(r_ovf), .parity_err(r_perr), .frame_err(r_ferr));

    // cycles during which each pulse output was high
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int raw_ferr_cnt = 0;
    always @(posedge clk) begin
        if (d_perr) perr_cnt <= perr_cnt + 1;
        if (d_ferr) ferr_cnt <= ferr_cnt + 1;
        if (r_ferr) raw_ferr_cnt <= raw_ferr_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [9:0] q_dec[$];
    logic [9:0] q_raw[$];
    bit m_ovf_dec, m_ovf_raw, m_ext, m_brk;

    function automatic void model_reset();
        q_dec.delete(); q_raw.delete();
        m_ovf_dec = 0; m_ovf_raw = 0; m_ext = 0; m_brk = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (q_raw.size() < DEPTH) q_raw.push_back({2'b00, b}); else m_ovf_raw = 1;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (q_dec.size() < DEPTH) q_dec.push_back({m_ext, m_brk, b}); else m_ovf_dec = 1;
            m_ext = 0; m_brk = 0;
        end
    endfunction

    function automatic void model_pop();
        if (q_dec.size() > 0) begin void'(q_dec.pop_front()); m_ovf_dec = 0; end
        if (q_raw.size() > 0) begin void'(q_raw.pop_front()); m_ovf_raw = 0; end
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".rdy"}, d_ready, q_dec.size() != 0);
        check({tag, ".lvl"}, d_level, q_dec.size());
        check({tag, ".ovf"}, d_ovf, m_ovf_dec);
        if (q_dec.size() != 0) check({tag, ".head"}, {d_ext, d_brk, d_data}, q_dec[0]);
        check({tag, ".raw_rdy"}, r_ready, q_raw.size() != 0);
        check({tag, ".raw_lvl"}, r_level, q_raw.size());
        check({tag, ".raw_ovf"}, r_ovf, m_ovf_raw);
        if (q_raw.size() != 0) check({tag, ".raw_head"}, {r_ext, r_brk, r_data}, q_raw[0]);
    endtask

    // ---------------- stimulus ----------------
    // Drives n bits; with pop_last, rdn is held low for exactly the cycle in
    // which the final byte is pushed (two cycles after the synchronised fall).
    task automatic send_bits(input logic [10:0] bits, input int n, input bit pop_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (pop_last && i == n - 1) begin
                repeat (4) @(negedge clk);
                rdn = 1'b0;
                @(negedge clk);
                rdn = 1'b1;
                repeat (HALF - 5) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input bit flip_par, input bit stop);
        return {stop, (~^b) ^ flip_par, b, 1'b0};
    endfunction

    task automatic send_good(input logic [7:0] b);
        send_bits(frame(b, 0, 1), 11, 0);
        model_byte(b);
    endtask

    task automatic send_parity_bad(input logic [7:0] b, input string tag);
        int p0 = perr_cnt, f0 = ferr_cnt;
        send_bits(frame(b, 1, 1), 11, 0);
        check({tag, ".perr"}, perr_cnt - p0, 1);
        check({tag, ".ferr"}, ferr_cnt - f0, 0);
    endtask

    task automatic send_stop_bad(input logic [7:0] b, input string tag);
        int p0 = perr_cnt, f0 = ferr_cnt;
        send_bits(frame(b, 0, 0), 11, 0);
        check({tag, ".ferr"}, ferr_cnt - f0, 1);
        check({tag, ".perr"}, perr_cnt - p0, 0);
    endtask

    task automatic pop_one();
        @(negedge clk);
        rdn = 1'b0;
        @(negedge clk);
        rdn = 1'b1;
        model_pop();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 2 * DEPTH && (q_dec.size() != 0 || q_raw.size() != 0); i++) begin
            pop_one();
            check_state(tag);
        end
    endtask

    initial begin
        int f0, k;
        logic [7:0] b;

        model_reset();
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.ready", d_ready, 0);
        check("rst.level", d_level, 0);
        check("rst.ovf", d_ovf, 0);
        check("rst.perr", d_perr, 0);
        check("rst.ferr", d_ferr, 0);
        check_state("rst");

        // single clean frame and pop
        send_good(8'h1C);
        check("1c.data", d_data, 8'h1C);
        check("1c.flags", {d_ext, d_brk}, 2'b00);
        check("1c.level", d_level, 1);
        check_state("1c");
        pop_one();
        check("1c_pop.ready", d_ready, 0);
        check_state("1c_pop");

        // extended break sequence
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        check("e0f075.head", {d_ext, d_brk, d_data}, {2'b11, 8'h75});
        check("e0f075.level", d_level, 1);
        check("e0f075.raw_level", r_level, 3);
        check_state("e0f075");
        drain("e0f075_drain");

        // error frames
        send_parity_bad(8'h23, "par23");
        check_state("par23");
        send_stop_bad(8'h23, "stop23");
        check_state("stop23");

        // watchdog: 5 bits then silence
        f0 = ferr_cnt;
        send_bits(frame(8'h55, 0, 1), 5, 0);
        repeat (TMO + 10) @(negedge clk);
        check("tmo.ferr", ferr_cnt - f0, 1);
        check_state("tmo");
        send_good(8'h1D);
        check("tmo_1d.data", d_data, 8'h1D);
        check_state("tmo_1d");
        drain("tmo_drain");

        // fill past full
        for (int i = 0; i < DEPTH + 1; i++) send_good(8'h30 + 8'(i));
        check("full.level", d_level, DEPTH);
        check("full.ovf", d_ovf, 1);
        check("full.head", d_data, 8'h30);
        check_state("full");
        pop_one();
        check("full_pop.ovf", d_ovf, 0);
        check("full_pop.level", d_level, DEPTH - 1);
        check_state("full_pop");
        send_good(8'h50);
        check_state("refill");
        send_bits(frame(8'h51, 0, 1), 11, 1);
        model_pop();
        model_byte(8'h51);
        check("full_push_pop.level", d_level, DEPTH);
        check("full_push_pop.ovf", d_ovf, 0);
        check_state("full_push_pop");
        drain("full_drain");

        // randomised traffic
        for (int it = 0; it < 30; it++) begin
            k = $urandom_range(0, 11);
            b = 8'($urandom_range(0, 255));
            case (k)
                0: send_good(8'hE0);
                1: send_good(8'hF0);
                2, 3, 4, 5, 6: send_good(b);
                7: send_parity_bad(b, "rnd_par");
                8: send_stop_bad(b, "rnd_stop");
                default: pop_one();
            endcase
            check_state("rnd");
        end
        drain("rnd_drain");

        // reset mid-frame
        send_good(8'h42);
        send_bits(frame(8'h99, 0, 1), 4, 0);
        @(negedge clk);
        clrn = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("midrst.ready", d_ready, 0);
        clrn = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst.level", d_level, 0);
        check("midrst.ovf", d_ovf, 0);
        check("midrst.perr", d_perr, 0);
        check("midrst.ferr", d_ferr, 0);
        check_state("midrst");
        f0 = ferr_cnt;
        send_good(8'h1B);
        check("post_rst.data", d_data, 8'h1B);
        check("post_rst.ferr", ferr_cnt - f0, 0);
        check_state("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
